scr1_pipe_wb_sched: RTL and testbench
=====================================

# scr1_pipe_wb_sched

Write-back scheduler and load scoreboard sitting directly upstream of the multi-port register file (MPRF) write port. It merges single-cycle EXU results with out-of-band LSU load responses into the MPRF's one write port. It tracks destination registers of outstanding loads and raises read-after-write and write-after-write hazards toward EXU. It also forwards a returning load value to EXU operands in the cycle it is written.

## Interface
- `LD_FIFO_DEPTH`, default 2: maximum outstanding loads (power of two, 1..4).
- `rst_n` in 1: asynchronous active-low reset.
- `clk` in 1: the block's single clock.
- `exu_wb_req` in 1: EXU requests a write-back.
- `exu_wb_addr` in `SCR1_MPRF_ADDR_WIDTH`: EXU destination register.
- `exu_wb_data` in `SCR1_XLEN`: EXU result.
- `exu_wb_rdy` out 1: EXU write accepted this cycle.
- `lsu_ld_issue` in 1: load issued to LSU.
- `lsu_ld_rd_addr` in `SCR1_MPRF_ADDR_WIDTH`: load destination.
- `lsu_ld_issue_rdy` out 1: issue accepted.
- `lsu_ld_resp_vld` in 1: load response, in issue order.
- `lsu_ld_resp_err` in 1: load faulted; no write.
- `lsu_ld_resp_data` in `SCR1_XLEN`: load data.
- `lsu_ld_resp_unexp` out 1: one-cycle pulse, response with no outstanding load.
- `exu_rs1_addr`, `exu_rs2_addr` in `SCR1_MPRF_ADDR_WIDTH`: EXU source addresses.
- `mprf_rs1_data`, `mprf_rs2_data` in `SCR1_XLEN`: MPRF read data.
- `exu_rs1_data`, `exu_rs2_data` out `SCR1_XLEN`: operands after forwarding.
- `exu_rs1_hazard`, `exu_rs2_hazard` out 1: operand not yet available; EXU stalls.
- `wb2mprf_w_req` out 1, `wb2mprf_rd_addr` out `SCR1_MPRF_ADDR_WIDTH`, `wb2mprf_rd_data` out `SCR1_XLEN`: MPRF write port.

## Operation
- State:
  - `pending[1:31]` bit vector, or `[1:15]` under `SCR1_RVE_EXT`.
  - Rd-address FIFO of `LD_FIFO_DEPTH` entries, with read/write pointers and a count.
- Issue:
  - `lsu_ld_issue_rdy = (count < DEPTH) && !(rd != 0 && pending[rd])`. This gives a WAW stall.
  - On `issue && rdy`: push rd; set `pending[rd]` when rd != 0.
  - A load to x0 is pushed with no pending bit set.
- Response:
  - On `lsu_ld_resp_vld` with count > 0: pop the head. This is the retire.
  - Head rd != 0 and no error: write the MPRF with the response data.
  - Clear `pending[head]` in both the write and the error case.
  - `lsu_ld_resp_vld` with count == 0: pulse `lsu_ld_resp_unexp`; state unchanged.
- Write arbitration, load has priority:
  - `exu_wb_rdy = !(load write this cycle) && !(exu_wb_addr != 0 && pending[exu_wb_addr])`.
  - An accepted EXU write to x0 is consumed; `w_req` stays 0.
  - `wb2mprf_w_req`: load write, else `exu_wb_req && exu_wb_rdy && addr != 0`.
  - Address and data are muxed from the same source as `w_req`; they are 0 when idle.
- Hazard and forwarding, per rsN:
  - `fwd = load write this cycle && head rd == rsN`.
  - `exu_rsN_data = fwd ? lsu_ld_resp_data : mprf_rsN_data`.
  - `exu_rsN_hazard = rsN != 0 && pending[rsN] && !fwd`.
  - An error retire to rsN does not forward. The hazard stays up that cycle and drops the next.
- Simultaneous issue and retire: both occur. Issue readiness uses the registered count and pending bits, so a full FIFO blocks issue even when a pop happens in the same cycle. A same-register issue/retire pair is impossible, because issue to a pending rd is blocked.

## Timing
- Reset, asynchronous and immediate:
  - State: pending all 0, FIFO empty, pointers 0.
  - Outputs: `exu_wb_rdy` = 1 and `lsu_ld_issue_rdy` = 1 for rd = 0 or any rd with inputs idle.
  - All other outputs 0 with idle inputs.
- Write, forward and hazard paths are combinational, with zero latency. The MPRF captures the write on the same `clk` edge.
- Pending bits and FIFO update on `posedge clk`. An issued rd's hazard is visible in the cycle after issue.
- Pointers wrap modulo `LD_FIFO_DEPTH`. Count ranges 0..DEPTH.
- Reset mid-operation discards outstanding loads. Responses arriving after reset flag `lsu_ld_resp_unexp`.

## Test plan
- Issue a load to x5, then respond with 0xDEADBEEF two cycles later. Required: `exu_rs1_hazard` = 1 for rs1 = 5 in the intervening cycle. In the response cycle, `wb2mprf_w_req` = 1 with addr 5 and data 0xDEADBEEF, `exu_rs1_data` = 0xDEADBEEF, and hazard = 0.
- In the load-response cycle, raise an EXU write to x7 with data 0x1. Required: `exu_wb_rdy` = 0 and the MPRF gets the load write. On the next cycle the EXU write is accepted: x7 = 0x1.
- Issue two loads, x3 then x4 (depth 2). Required: a third issue has `rdy` = 0. Responses write x3 then x4 in order. `rdy` returns to 1 the cycle after the first response.
- Issue a load to x9 and respond with `lsu_ld_resp_err` = 1. Required: no MPRF write and `pending[9]` clears. Hazard on x9 is 1 in the response cycle and 0 the next.
- Issue a load to x9, then drive an EXU write to x9 and a second load to x9. Required: both are stalled until the load response.
- Drive a response with no outstanding load. Required: `lsu_ld_resp_unexp` pulses for one cycle with no write. Assert `rst_n` low with loads outstanding. Required: all hazards 0 and the FIFO empty.

Source files
------------

// File: rtl/scr1_pipe_wb_sched_if.sv
// Signal bundle between the write-back scheduler and its EXU, LSU and MPRF neighbours.
// The slave modport is the scheduler's view; the master modport is the surrounding pipeline's view.
interface scr1_pipe_wb_sched_if;
`ifdef SCR1_RVE_EXT
  localparam int AW = 4;
`else
  localparam int AW = 5;
`endif
  localparam int XLEN = 32;

  logic            exu_wb_req;
  logic [AW-1:0]   exu_wb_addr;
  logic [XLEN-1:0] exu_wb_data;
  logic            exu_wb_rdy;

  logic            lsu_ld_issue;
  logic [AW-1:0]   lsu_ld_rd_addr;
  logic            lsu_ld_issue_rdy;
  logic            lsu_ld_resp_vld;
  logic            lsu_ld_resp_err;
  logic [XLEN-1:0] lsu_ld_resp_data;
  logic            lsu_ld_resp_unexp;

  logic [AW-1:0]   exu_rs1_addr;
  logic [AW-1:0]   exu_rs2_addr;
  logic [XLEN-1:0] mprf_rs1_data;
  logic [XLEN-1:0] mprf_rs2_data;
  logic [XLEN-1:0] exu_rs1_data;
  logic [XLEN-1:0] exu_rs2_data;
  logic            exu_rs1_hazard;
  logic            exu_rs2_hazard;

  logic            wb2mprf_w_req;
  logic [AW-1:0]   wb2mprf_rd_addr;
  logic [XLEN-1:0] wb2mprf_rd_data;

  modport slave (
    input  exu_wb_req, exu_wb_addr, exu_wb_data,
    output exu_wb_rdy,
    input  lsu_ld_issue, lsu_ld_rd_addr,
    output lsu_ld_issue_rdy,
    input  lsu_ld_resp_vld, lsu_ld_resp_err, lsu_ld_resp_data,
    output lsu_ld_resp_unexp,
    input  exu_rs1_addr, exu_rs2_addr, mprf_rs1_data, mprf_rs2_data,
    output exu_rs1_data, exu_rs2_data, exu_rs1_hazard, exu_rs2_hazard,
    output wb2mprf_w_req, wb2mprf_rd_addr, wb2mprf_rd_data
  );

  modport master (
    output exu_wb_req, exu_wb_addr, exu_wb_data,
    input  exu_wb_rdy,
    output lsu_ld_issue, lsu_ld_rd_addr,
    input  lsu_ld_issue_rdy,
    output lsu_ld_resp_vld, lsu_ld_resp_err, lsu_ld_resp_data,
    input  lsu_ld_resp_unexp,
    output exu_rs1_addr, exu_rs2_addr, mprf_rs1_data, mprf_rs2_data,
    input  exu_rs1_data, exu_rs2_data, exu_rs1_hazard, exu_rs2_hazard,
    input  wb2mprf_w_req, wb2mprf_rd_addr, wb2mprf_rd_data
  );
endinterface

// File: rtl/scr1_pipe_wb_sched.sv
// Write-back scheduler: merges EXU results and in-order LSU load responses onto the single
// MPRF write port, tracks outstanding load destinations and forwards returning load data.
module scr1_pipe_wb_sched #(
  parameter int LD_FIFO_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  scr1_pipe_wb_sched_if.slave wb
);
`ifdef SCR1_RVE_EXT
  localparam int AW = 4;
`else
  localparam int AW = 5;
`endif
  localparam int NREG  = 1 << AW;
  localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(LD_FIFO_DEPTH + 1);

  logic [NREG-1:0]  pending_q, pending_d;
  logic [AW-1:0]    rd_fifo_q [LD_FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [AW-1:0] head_rd;
  logic          fifo_empty;
  logic          fifo_full;
  logic          issue_fire;
  logic          ld_retire;
  logic          ld_wr;
  logic          exu_wr;
  logic          fwd_rs1;
  logic          fwd_rs2;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(LD_FIFO_DEPTH - 1)) return '0;
    else                                return p + 1'b1;
  endfunction

  // Issue/retire decode from registered state only
  assign head_rd    = rd_fifo_q[rptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(LD_FIFO_DEPTH));

  assign wb.lsu_ld_issue_rdy = !fifo_full &&
                               !((wb.lsu_ld_rd_addr != '0) && pending_q[wb.lsu_ld_rd_addr]);
  assign issue_fire          = wb.lsu_ld_issue && wb.lsu_ld_issue_rdy;

  assign ld_retire             = wb.lsu_ld_resp_vld && !fifo_empty;
  assign ld_wr                 = ld_retire && !wb.lsu_ld_resp_err && (head_rd != '0);
  assign wb.lsu_ld_resp_unexp  = wb.lsu_ld_resp_vld && fifo_empty;

  // Write-port arbitration: a load write always wins the port
  assign wb.exu_wb_rdy = !ld_wr &&
                         !((wb.exu_wb_addr != '0) && pending_q[wb.exu_wb_addr]);
  assign exu_wr        = wb.exu_wb_req && wb.exu_wb_rdy && (wb.exu_wb_addr != '0);

  always_comb begin
    wb.wb2mprf_w_req   = ld_wr || exu_wr;
    wb.wb2mprf_rd_addr = '0;
    wb.wb2mprf_rd_data = '0;
    if (ld_wr) begin
      wb.wb2mprf_rd_addr = head_rd;
      wb.wb2mprf_rd_data = wb.lsu_ld_resp_data;
    end else if (exu_wr) begin
      wb.wb2mprf_rd_addr = wb.exu_wb_addr;
      wb.wb2mprf_rd_data = wb.exu_wb_data;
    end
  end

  // Operand forwarding; an errored retire never forwards, so its hazard holds one more cycle
  assign fwd_rs1 = ld_wr && (head_rd == wb.exu_rs1_addr);
  assign fwd_rs2 = ld_wr && (head_rd == wb.exu_rs2_addr);

  assign wb.exu_rs1_data   = fwd_rs1 ? wb.lsu_ld_resp_data : wb.mprf_rs1_data;
  assign wb.exu_rs2_data   = fwd_rs2 ? wb.lsu_ld_resp_data : wb.mprf_rs2_data;
  assign wb.exu_rs1_hazard = (wb.exu_rs1_addr != '0) && pending_q[wb.exu_rs1_addr] && !fwd_rs1;
  assign wb.exu_rs2_hazard = (wb.exu_rs2_addr != '0) && pending_q[wb.exu_rs2_addr] && !fwd_rs2;

  // Scoreboard next state; retire and issue never target the same register in one cycle
  always_comb begin
    pending_d = pending_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    if (ld_retire) begin
      pending_d[head_rd] = 1'b0;
      rptr_d             = ptr_inc(rptr_q);
    end
    if (issue_fire) begin
      if (wb.lsu_ld_rd_addr != '0) pending_d[wb.lsu_ld_rd_addr] = 1'b1;
      wptr_d = ptr_inc(wptr_q);
    end
    case ({issue_fire, ld_retire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    pending_d[0] = 1'b0;
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Destination storage carries no reset; occupancy is governed by cnt_q
  always_ff @(posedge clk) begin
    if (issue_fire) rd_fifo_q[wptr_q] <= wb.lsu_ld_rd_addr;
  end

endmodule

// File: tb/tb_scr1_pipe_wb_sched.sv
// Directed bench for the write-back scheduler with the default two-entry load FIFO.
module tb_scr1_pipe_wb_sched;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  scr1_pipe_wb_sched_if wb_if ();

  scr1_pipe_wb_sched #(.LD_FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb_if.exu_wb_req       = 1'b0;
    wb_if.exu_wb_addr      = '0;
    wb_if.exu_wb_data      = '0;
    wb_if.lsu_ld_issue     = 1'b0;
    wb_if.lsu_ld_rd_addr   = '0;
    wb_if.lsu_ld_resp_vld  = 1'b0;
    wb_if.lsu_ld_resp_err  = 1'b0;
    wb_if.lsu_ld_resp_data = '0;
    wb_if.exu_rs1_addr     = '0;
    wb_if.exu_rs2_addr     = '0;
    wb_if.mprf_rs1_data    = '0;
    wb_if.mprf_rs2_data    = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_exu_rdy",   32'(wb_if.exu_wb_rdy), 32'd1);
    chk("rst_issue_rdy", 32'(wb_if.lsu_ld_issue_rdy), 32'd1);
    chk("rst_wreq",      32'(wb_if.wb2mprf_w_req), 32'd0);
    chk("rst_waddr",     32'(wb_if.wb2mprf_rd_addr), 32'd0);
    chk("rst_unexp",     32'(wb_if.lsu_ld_resp_unexp), 32'd0);
    chk("rst_haz1",      32'(wb_if.exu_rs1_hazard), 32'd0);
    chk("rst_rs1_data",  wb_if.exu_rs1_data, 32'd0);
    wb_if.lsu_ld_rd_addr = 5'd5;
    #1;
    chk("rst_issue_rdy_x5", 32'(wb_if.lsu_ld_issue_rdy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Load to x5, response two cycles later with EXU write to x7 colliding
    cyc();
    wb_if.lsu_ld_issue = 1'b1; wb_if.lsu_ld_rd_addr = 5'd5;
    #2 chk("x5_issue_rdy", 32'(wb_if.lsu_ld_issue_rdy), 32'd1);
    cyc();
    wb_if.exu_rs1_addr = 5'd5;
    #2 chk("x5_haz_wait", 32'(wb_if.exu_rs1_hazard), 32'd1);
    cyc();
    wb_if.lsu_ld_resp_vld = 1'b1; wb_if.lsu_ld_resp_data = 32'hDEADBEEF;
    wb_if.exu_rs1_addr = 5'd5; wb_if.mprf_rs1_data = 32'h11111111;
    wb_if.exu_wb_req = 1'b1; wb_if.exu_wb_addr = 5'd7; wb_if.exu_wb_data = 32'h1;
    #2;
    chk("x5_wreq",     32'(wb_if.wb2mprf_w_req), 32'd1);
    chk("x5_waddr",    32'(wb_if.wb2mprf_rd_addr), 32'd5);
    chk("x5_wdata",    wb_if.wb2mprf_rd_data, 32'hDEADBEEF);
    chk("x5_fwd",      wb_if.exu_rs1_data, 32'hDEADBEEF);
    chk("x5_haz_resp", 32'(wb_if.exu_rs1_hazard), 32'd0);
    chk("x7_blocked",  32'(wb_if.exu_wb_rdy), 32'd0);
    cyc();
    wb_if.exu_wb_req = 1'b1; wb_if.exu_wb_addr = 5'd7; wb_if.exu_wb_data = 32'h1;
    wb_if.exu_rs1_addr = 5'd5; wb_if.mprf_rs1_data = 32'h22222222;
    #2;
    chk("x7_rdy",     32'(wb_if.exu_wb_rdy), 32'd1);
    chk("x7_wreq",    32'(wb_if.wb2mprf_w_req), 32'd1);
    chk("x7_waddr",   32'(wb_if.wb2mprf_rd_addr), 32'd7);
    chk("x7_wdata",   wb_if.wb2mprf_rd_data, 32'h1);
    chk("x5_nofwd",   wb_if.exu_rs1_data, 32'h22222222);
    chk("x5_haz_gone", 32'(wb_if.exu_rs1_hazard), 32'd0);

    // Two loads fill the FIFO; in-order responses
    cyc();
    wb_if.lsu_ld_issue = 1'b1; wb_if.lsu_ld_rd_addr = 5'd3;
    #2 chk("x3_issue_rdy", 32'(wb_if.lsu_ld_issue_rdy), 32'd1);
    cyc();
    wb_if.lsu_ld_issue = 1'b1; wb_if.lsu_ld_rd_addr = 5'd4;
    #2 chk("x4_issue_rdy", 32'(wb_if.lsu_ld_issue_rdy), 32'd1);
    cyc();
    wb_if.lsu_ld_rd_addr = 5'd6;
    wb_if.exu_rs1_addr = 5'd3; wb_if.exu_rs2_addr = 5'd4;
    #2;
    chk("full_rdy",  32'(wb_if.lsu_ld_issue_rdy), 32'd0);
    chk("x3_haz",    32'(wb_if.exu_rs1_hazard), 32'd1);
    chk("x4_haz",    32'(wb_if.exu_rs2_hazard), 32'd1);
    cyc();
    wb_if.lsu_ld_resp_vld = 1'b1; wb_if.lsu_ld_resp_data = 32'hAAAA0003;
    wb_if.lsu_ld_rd_addr = 5'd6;
    wb_if.exu_rs1_addr = 5'd3; wb_if.exu_rs2_addr = 5'd4;
    #2;
    chk("r1_wreq",    32'(wb_if.wb2mprf_w_req), 32'd1);
    chk("r1_waddr",   32'(wb_if.wb2mprf_rd_addr), 32'd3);
    chk("r1_wdata",   wb_if.wb2mprf_rd_data, 32'hAAAA0003);
    chk("r1_full_rdy", 32'(wb_if.lsu_ld_issue_rdy), 32'd0);
    chk("r1_x4_haz",  32'(wb_if.exu_rs2_hazard), 32'd1);
    cyc();
    wb_if.lsu_ld_rd_addr = 5'd6;
    #2 chk("r1_after_rdy", 32'(wb_if.lsu_ld_issue_rdy), 32'd1);
    cyc();
    wb_if.lsu_ld_resp_vld = 1'b1; wb_if.lsu_ld_resp_data = 32'hBBBB0004;
    #2;
    chk("r2_waddr", 32'(wb_if.wb2mprf_rd_addr), 32'd4);
    chk("r2_wdata", wb_if.wb2mprf_rd_data, 32'hBBBB0004);

    // Faulting load to x9
    cyc();
    wb_if.lsu_ld_issue = 1'b1; wb_if.lsu_ld_rd_addr = 5'd9;
    cyc();
    wb_if.lsu_ld_resp_vld = 1'b1; wb_if.lsu_ld_resp_err = 1'b1;
    wb_if.lsu_ld_resp_data = 32'h12345678;
    wb_if.exu_rs1_addr = 5'd9; wb_if.mprf_rs1_data = 32'h00000055;
    #2;
    chk("err_wreq",  32'(wb_if.wb2mprf_w_req), 32'd0);
    chk("err_haz",   32'(wb_if.exu_rs1_hazard), 32'd1);
    chk("err_nofwd", wb_if.exu_rs1_data, 32'h00000055);
    chk("err_unexp", 32'(wb_if.lsu_ld_resp_unexp), 32'd0);
    cyc();
    wb_if.exu_rs1_addr = 5'd9; wb_if.lsu_ld_rd_addr = 5'd9;
    #2;
    chk("err_haz_next", 32'(wb_if.exu_rs1_hazard), 32'd0);
    chk("err_x9_free",  32'(wb_if.lsu_ld_issue_rdy), 32'd1);

    // WAW stalls on x9 for both EXU write and second load
    cyc();
    wb_if.lsu_ld_issue = 1'b1; wb_if.lsu_ld_rd_addr = 5'd9;
    for (int i = 0; i < 2; i++) begin
      cyc();
      wb_if.exu_wb_req = 1'b1; wb_if.exu_wb_addr = 5'd9; wb_if.exu_wb_data = 32'h2;
      wb_if.lsu_ld_issue = 1'b1; wb_if.lsu_ld_rd_addr = 5'd9;
      #2;
      chk("waw_exu_stall",   32'(wb_if.exu_wb_rdy), 32'd0);
      chk("waw_issue_stall", 32'(wb_if.lsu_ld_issue_rdy), 32'd0);
      chk("waw_wreq",        32'(wb_if.wb2mprf_w_req), 32'd0);
    end
    cyc();
    wb_if.exu_wb_req = 1'b1; wb_if.exu_wb_addr = 5'd9; wb_if.exu_wb_data = 32'h2;
    wb_if.lsu_ld_issue = 1'b1; wb_if.lsu_ld_rd_addr = 5'd9;
    wb_if.lsu_ld_resp_vld = 1'b1; wb_if.lsu_ld_resp_data = 32'hCAFEF00D;
    #2;
    chk("waw_ld_waddr", 32'(wb_if.wb2mprf_rd_addr), 32'd9);
    chk("waw_ld_wdata", wb_if.wb2mprf_rd_data, 32'hCAFEF00D);
    chk("waw_exu_busy", 32'(wb_if.exu_wb_rdy), 32'd0);
    chk("waw_iss_busy", 32'(wb_if.lsu_ld_issue_rdy), 32'd0);
    cyc();
    wb_if.exu_wb_req = 1'b1; wb_if.exu_wb_addr = 5'd9; wb_if.exu_wb_data = 32'h2;
    wb_if.lsu_ld_issue = 1'b1; wb_if.lsu_ld_rd_addr = 5'd9;
    #2;
    chk("waw_exu_go",    32'(wb_if.exu_wb_rdy), 32'd1);
    chk("waw_exu_wdata", wb_if.wb2mprf_rd_data, 32'h2);
    chk("waw_iss_go",    32'(wb_if.lsu_ld_issue_rdy), 32'd1);

    // Second outstanding load, then asynchronous reset mid-operation
    cyc();
    wb_if.lsu_ld_issue = 1'b1; wb_if.lsu_ld_rd_addr = 5'd2;
    cyc();
    wb_if.exu_rs1_addr = 5'd9; wb_if.exu_rs2_addr = 5'd2; wb_if.lsu_ld_rd_addr = 5'd9;
    #2;
    chk("pre_rst_haz1", 32'(wb_if.exu_rs1_hazard), 32'd1);
    chk("pre_rst_haz2", 32'(wb_if.exu_rs2_hazard), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_haz1", 32'(wb_if.exu_rs1_hazard), 32'd0);
    chk("mid_rst_haz2", 32'(wb_if.exu_rs2_hazard), 32'd0);
    chk("mid_rst_rdy",  32'(wb_if.lsu_ld_issue_rdy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Response with nothing outstanding
    cyc();
    wb_if.lsu_ld_resp_vld = 1'b1; wb_if.lsu_ld_resp_data = 32'h99999999;
    #2;
    chk("unexp_pulse", 32'(wb_if.lsu_ld_resp_unexp), 32'd1);
    chk("unexp_wreq",  32'(wb_if.wb2mprf_w_req), 32'd0);
    cyc();
    #2;
    chk("unexp_drop", 32'(wb_if.lsu_ld_resp_unexp), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
